// File: rtl/pixel_seq_pkg.sv
// pixel_seq_pkg
//   Shared types and default parameter values for the pixel sequencer.
//   state_t is the sequencer FSM state; it is also exported on the top-level
//   debug port so checkers can observe the phase directly.
package pixel_seq_pkg;

  localparam int N_PIX_DEF     = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int ERASE_CYC_DEF = 5;
  localparam int EXP_W_DEF     = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4
  } state_t;

endpackage

// File: rtl/pixel_seq_ctrl_if.sv
// pixel_seq_ctrl_if
//   Readout stream carrying one pixel word per transfer.
//   Signals: out_data (word), out_valid, out_ready, out_last (final channel).
//
//   Handshake: a word transfers on a rising edge where out_valid && out_ready.
//   Once out_valid is raised, out_data/out_valid/out_last stay constant until
//   that transfer happens. out_ready may toggle freely and never gates
//   out_valid. out_last marks the final word of a frame.
interface pixel_seq_ctrl_if #(
  parameter int DATA_W = pixel_seq_pkg::DATA_W_DEF
) ();
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/pixel_seq_serializer.sv
// pixel_seq_serializer
//   Captures the parallel pixel bus into holding registers and streams the
//   channels out in order 0..N_PIX-1 over the valid/ready interface.
//   Ports:
//     clk, reset     - clock, synchronous active-high reset
//     capture_i      - load pix_data_i into the holding registers and arm the stream
//     pix_data_i     - pixel bus, channel i at [i*DATA_W +: DATA_W]
//     stream         - readout stream (master side)
//     last_hs_o      - high in the cycle the final channel is transferred
module pixel_seq_serializer
  import pixel_seq_pkg::*;
#(
  parameter int N_PIX  = N_PIX_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    capture_i,
  input  logic [N_PIX*DATA_W-1:0] pix_data_i,
  pixel_seq_ctrl_if.master        stream,
  output logic                    last_hs_o
);

  localparam int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;

  logic [DATA_W-1:0] hold_q [N_PIX];
  logic [DATA_W-1:0] hold_d [N_PIX];
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              hs;
  logic              is_last;
  logic              show;

  assign is_last   = (idx_q == IDX_W'(N_PIX - 1));
  assign hs        = valid_q && stream.out_ready;
  assign last_hs_o = hs && is_last;

  always_comb begin
    hold_d  = hold_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (capture_i) begin
      for (int i = 0; i < N_PIX; i++) begin
        hold_d[i] = pix_data_i[i*DATA_W +: DATA_W];
      end
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (hs) begin
      if (is_last) begin
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_PIX; i++) begin
        hold_q[i] <= '0;
      end
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Outputs are forced low while reset is asserted, not just after the edge.
  assign show             = valid_q && !reset;
  assign stream.out_valid = show;
  assign stream.out_data  = show ? hold_q[idx_q] : '0;
  assign stream.out_last  = show && is_last;

endmodule

// File: rtl/pixel_seq_ctrl.sv
// pixel_seq_ctrl
//   Pixel array frame sequencer: ERASE -> EXPOSE -> CONVERT (ramp ADC) -> READ,
//   optionally repeating frames back to back.
//   Ports:
//     clk, reset                  - clock, synchronous active-high reset
//     start                       - frame request, honoured only in IDLE
//     exp_cycles                  - exposure length, latched at frame start
//     continuous                  - at frame end, go straight to the next frame
//     erase/expose/convert/read   - phase strobes, one-hot outside IDLE
//     ramp_code                   - ADC ramp, counts 0..2^DATA_W-1 during CONVERT
//     pix_data                    - pixel bus, channel i at [i*DATA_W +: DATA_W]
//     stream                      - readout stream (out_data/valid/ready/last)
//     busy                        - high whenever not IDLE
//     frame_done                  - one-cycle pulse after the last word transfers
//     dbg_state_o                 - current FSM state
module pixel_seq_ctrl
  import pixel_seq_pkg::*;
#(
  parameter int N_PIX     = N_PIX_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ERASE_CYC = ERASE_CYC_DEF,
  parameter int EXP_W     = EXP_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [EXP_W-1:0]        exp_cycles,
  input  logic                    continuous,
  output logic                    erase,
  output logic                    expose,
  output logic                    convert,
  output logic                    read,
  output logic [DATA_W-1:0]       ramp_code,
  input  logic [N_PIX*DATA_W-1:0] pix_data,
  pixel_seq_ctrl_if.master        stream,
  output logic                    busy,
  output logic                    frame_done,
  output state_t                  dbg_state_o
);

  localparam int ERASE_W = $clog2(ERASE_CYC + 1);
  localparam int CNT_W   = (EXP_W > ERASE_W) ? EXP_W : ERASE_W;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  ramp_q, ramp_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic               frame_done_q, frame_done_d;
  logic               capture;
  logic               last_hs;
  logic [CNT_W-1:0]   expose_end;
  logic               run;

  // A zero exposure request still gets one EXPOSE cycle.
  assign expose_end = (exp_q == '0) ? '0 : CNT_W'(exp_q - EXP_W'(1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ramp_d       = '0;
    exp_d        = exp_q;
    frame_done_d = 1'b0;
    capture      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = ST_ERASE;
          exp_d   = exp_cycles;
        end
      end
      ST_ERASE: begin
        if (cnt_q == CNT_W'(ERASE_CYC - 1)) begin
          state_d = ST_EXPOSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EXPOSE: begin
        if (cnt_q == expose_end) begin
          state_d = ST_CONVERT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CONVERT: begin
        ramp_d = ramp_q + DATA_W'(1);
        if (ramp_q == {DATA_W{1'b1}}) begin
          state_d = ST_READ;
          ramp_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_READ: begin
        // cnt_q == 0 only in the first READ cycle: that is the capture cycle.
        capture = (cnt_q == '0);
        cnt_d   = CNT_W'(1);
        if (last_hs) begin
          frame_done_d = 1'b1;
          cnt_d        = '0;
          if (continuous) begin
            state_d = ST_ERASE;
            exp_d   = exp_cycles;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ramp_q       <= '0;
      exp_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ramp_q       <= ramp_d;
      exp_q        <= exp_d;
      frame_done_q <= frame_done_d;
    end
  end

  pixel_seq_serializer #(
    .N_PIX  (N_PIX),
    .DATA_W (DATA_W)
  ) u_ser (
    .clk        (clk),
    .reset      (reset),
    .capture_i  (capture),
    .pix_data_i (pix_data),
    .stream     (stream),
    .last_hs_o  (last_hs)
  );

  // Outputs are forced low while reset is asserted, not just after the edge.
  assign run         = !reset;
  assign erase       = run && (state_q == ST_ERASE);
  assign expose      = run && (state_q == ST_EXPOSE);
  assign convert     = run && (state_q == ST_CONVERT);
  assign read        = run && (state_q == ST_READ);
  assign ramp_code   = (run && (state_q == ST_CONVERT)) ? ramp_q : '0;
  assign busy        = run && (state_q != ST_IDLE);
  assign frame_done  = run && frame_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// tb_pixel_seq_ctrl
//   Self-checking bench for pixel_seq_ctrl. Inputs are driven and outputs
//   sampled on the falling edge. observe_frame records what a frame looked
//   like (phase lengths, ramp, streamed words); each test compares those
//   observations against values derived from the frame rules.
module tb_pixel_seq_ctrl;
  import pixel_seq_pkg::*;

  localparam int N_PIX     = 4;
  localparam int DATA_W    = 8;
  localparam int ERASE_CYC = 5;
  localparam int EXP_W     = 16;
  localparam int PW        = N_PIX * DATA_W;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              continuous = 1'b0;
  logic [EXP_W-1:0]  exp_cycles = '0;
  logic [PW-1:0]     pix_data = '0;
  logic              erase, expose, convert, read, busy, frame_done;
  logic [DATA_W-1:0] ramp_code;
  state_t            dbg_state;

  pixel_seq_ctrl_if #(.DATA_W(DATA_W)) s_if ();

  always #5 clk = ~clk;

  pixel_seq_ctrl #(
    .N_PIX(N_PIX), .DATA_W(DATA_W), .ERASE_CYC(ERASE_CYC), .EXP_W(EXP_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .exp_cycles(exp_cycles),
    .continuous(continuous), .erase(erase), .expose(expose), .convert(convert),
    .read(read), .ramp_code(ramp_code), .pix_data(pix_data), .stream(s_if),
    .busy(busy), .frame_done(frame_done), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] exp_q[$];

  int   obs_erase, obs_expose, obs_convert, obs_read;
  int   obs_ramp_err, obs_strobe_err, obs_order_err, obs_hold_err, obs_fd_gap;
  logic obs_valid_first, obs_end_erase, obs_end_busy, obs_timeout;
  logic [DATA_W-1:0] obs_words[$];
  logic              obs_lasts[$];

  // Reference: channel words in stream order.
  task automatic load_model(input logic [PW-1:0] pix);
    exp_q.delete();
    for (int i = 0; i < N_PIX; i++) exp_q.push_back(pix[i*DATA_W +: DATA_W]);
  endtask

  function automatic int model_expose(input int e);
    return (e == 0) ? 1 : e;
  endfunction

  // Reference: READ length = capture cycle + valid cycles until N_PIX transfers.
  function automatic int model_read_len(input logic [31:0] pat, input int len);
    int k = 0;
    int words = 0;
    while (words < N_PIX) begin
      if ((k < len) ? pat[k] : 1'b1) words++;
      k++;
    end
    return 1 + k;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [EXP_W-1:0] e);
    @(negedge clk);
    exp_cycles = e;
    start = 1'b1;
  endtask

  // Follows one frame until frame_done, recording phase lengths and words.
  // ready_pat[k] drives out_ready for the k-th cycle with out_valid high.
  task automatic observe_frame(input logic [31:0] ready_pat, input int pat_len,
                               input int pre_erase, input logic change_pix,
                               input logic [EXP_W-1:0] exp_after, input int poke_at);
    int code, last_code, vcnt, conv_idx, read_cyc, last_hs_cyc;
    logic stalled, prev_last, hs;
    logic [DATA_W-1:0] prev_data;
    obs_erase = pre_erase; obs_expose = 0; obs_convert = 0; obs_read = 0;
    obs_ramp_err = 0; obs_strobe_err = 0; obs_order_err = 0; obs_hold_err = 0;
    obs_fd_gap = -1; obs_valid_first = 0; obs_end_erase = 0; obs_end_busy = 0;
    obs_timeout = 1; obs_words.delete(); obs_lasts.delete();
    last_code = (pre_erase > 0) ? 1 : 0;
    vcnt = 0; conv_idx = 0; read_cyc = 0; last_hs_cyc = -100;
    stalled = 0; prev_last = 0; prev_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin start = 1'b0; exp_cycles = exp_after; end
      if (cyc == poke_at) start = 1'b1;
      else if (cyc == poke_at + 1) start = 1'b0;
      if (frame_done) begin
        obs_fd_gap = cyc - last_hs_cyc;
        obs_end_erase = erase;
        obs_end_busy = busy;
        obs_timeout = 0;
        break;
      end
      code = erase ? 1 : expose ? 2 : convert ? 3 : read ? 4 : 0;
      if (int'(erase) + int'(expose) + int'(convert) + int'(read) > 1) obs_strobe_err++;
      if (code == 0 || busy !== 1'b1) obs_strobe_err++;
      if (code < last_code) obs_order_err++;
      last_code = code;
      if (code == 1) obs_erase++;
      if (code == 2) obs_expose++;
      if (code == 3) begin
        if (ramp_code !== DATA_W'(conv_idx)) obs_ramp_err++;
        conv_idx++;
        obs_convert++;
      end else if (ramp_code !== '0) obs_ramp_err++;
      if (code == 4) begin
        read_cyc++;
        obs_read++;
        if (read_cyc == 1 && s_if.out_valid) obs_valid_first = 1;
        if (stalled && (s_if.out_valid !== 1'b1 || s_if.out_data !== prev_data ||
                        s_if.out_last !== prev_last)) obs_hold_err++;
        if (s_if.out_valid) begin
          s_if.out_ready = (vcnt < pat_len) ? ready_pat[vcnt] : 1'b1;
          vcnt++;
          if (change_pix) pix_data = PW'($urandom());
        end else begin
          s_if.out_ready = 1'b1;
        end
        hs = s_if.out_valid && s_if.out_ready;
        if (hs) begin
          obs_words.push_back(s_if.out_data);
          obs_lasts.push_back(s_if.out_last);
          last_hs_cyc = cyc;
        end
        stalled = s_if.out_valid && !s_if.out_ready;
        prev_data = s_if.out_data;
        prev_last = s_if.out_last;
      end else begin
        s_if.out_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b1; continuous = 1'b1; exp_cycles = 16'd7;
    s_if.out_ready = 1'b1; pix_data = PW'($urandom());
    repeat (3) @(negedge clk);
    n_checks++; if ({erase, expose, convert, read} !== 4'b0) $display("FAIL reset_strobes got %b want 0000", {erase, expose, convert, read}); else n_pass++;
    n_checks++; if (ramp_code !== '0) $display("FAIL reset_ramp got %0d want 0", ramp_code); else n_pass++;
    n_checks++; if ({s_if.out_valid, s_if.out_last} !== 2'b0) $display("FAIL reset_valid_last got %b want 00", {s_if.out_valid, s_if.out_last}); else n_pass++;
    n_checks++; if (s_if.out_data !== '0) $display("FAIL reset_out_data got %h want 00", s_if.out_data); else n_pass++;
    n_checks++; if ({busy, frame_done} !== 2'b0) $display("FAIL reset_busy_done got %b want 00", {busy, frame_done}); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    reset = 1'b0; start = 1'b0; continuous = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL post_reset_idle got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_nominal();
    pix_data = 32'h44332211;
    load_model(pix_data);
    continuous = 1'b0;
    do_start(16'd10);
    observe_frame(32'hFFFF_FFFF, 32, 0, 1'b0, 16'd10, -1);
    n_checks++; if (obs_timeout !== 1'b0) $display("FAIL nominal_timeout got %b want 0", obs_timeout); else n_pass++;
    n_checks++; if (obs_erase !== ERASE_CYC) $display("FAIL nominal_erase got %0d want %0d", obs_erase, ERASE_CYC); else n_pass++;
    n_checks++; if (obs_expose !== 10) $display("FAIL nominal_expose got %0d want 10", obs_expose); else n_pass++;
    n_checks++; if (obs_convert !== (1 << DATA_W)) $display("FAIL nominal_convert got %0d want %0d", obs_convert, 1 << DATA_W); else n_pass++;
    n_checks++; if (obs_ramp_err !== 0) $display("FAIL nominal_ramp got %0d bad cycles want 0", obs_ramp_err); else n_pass++;
    n_checks++; if (obs_strobe_err + obs_order_err !== 0) $display("FAIL nominal_strobes got %0d bad cycles want 0", obs_strobe_err + obs_order_err); else n_pass++;
    n_checks++; if (obs_valid_first !== 1'b0) $display("FAIL nominal_first_read_valid got %b want 0", obs_valid_first); else n_pass++;
    n_checks++; if (obs_read !== 1 + N_PIX) $display("FAIL nominal_read_len got %0d want %0d", obs_read, 1 + N_PIX); else n_pass++;
    n_checks++; if (obs_words.size() !== N_PIX) $display("FAIL nominal_word_count got %0d want %0d", obs_words.size(), N_PIX); else n_pass++;
    for (int i = 0; i < N_PIX && i < obs_words.size(); i++) begin
      logic lw = (i == N_PIX - 1);
      n_checks++; if ({obs_lasts[i], obs_words[i]} !== {lw, exp_q[i]}) $display("FAIL nominal_word%0d got last=%b data=%h want last=%b data=%h", i, obs_lasts[i], obs_words[i], lw, exp_q[i]); else n_pass++;
    end
    n_checks++; if (obs_fd_gap !== 1) $display("FAIL nominal_done_gap got %0d want 1", obs_fd_gap); else n_pass++;
    n_checks++; if ({obs_end_busy, obs_end_erase} !== 2'b0) $display("FAIL nominal_end_idle got busy=%b erase=%b want 0 0", obs_end_busy, obs_end_erase); else n_pass++;
    @(negedge clk);
    n_checks++; if ({busy, frame_done} !== 2'b0) $display("FAIL nominal_after got busy=%b done=%b want 0 0", busy, frame_done); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] pat = 32'b1101001;  // ready per valid cycle: 1,0,0,1,0,1,1
    pix_data = PW'($urandom());
    load_model(pix_data);
    do_start(16'd3);
    observe_frame(pat, 7, 0, 1'b0, 16'd3, -1);
    n_checks++; if (obs_timeout !== 1'b0) $display("FAIL bp_timeout got %b want 0", obs_timeout); else n_pass++;
    n_checks++; if (obs_hold_err !== 0) $display("FAIL bp_hold got %0d unstable cycles want 0", obs_hold_err); else n_pass++;
    n_checks++; if (obs_read !== model_read_len(pat, 7)) $display("FAIL bp_read_len got %0d want %0d", obs_read, model_read_len(pat, 7)); else n_pass++;
    n_checks++; if (obs_words.size() !== N_PIX) $display("FAIL bp_word_count got %0d want %0d", obs_words.size(), N_PIX); else n_pass++;
    for (int i = 0; i < N_PIX && i < obs_words.size(); i++) begin
      logic lw = (i == N_PIX - 1);
      n_checks++; if ({obs_lasts[i], obs_words[i]} !== {lw, exp_q[i]}) $display("FAIL bp_word%0d got last=%b data=%h want last=%b data=%h", i, obs_lasts[i], obs_words[i], lw, exp_q[i]); else n_pass++;
    end
    n_checks++; if (obs_fd_gap !== 1) $display("FAIL bp_done_gap got %0d want 1", obs_fd_gap); else n_pass++;
  endtask

  task automatic test_zero_exposure();
    for (int e = 0; e < 2; e++) begin
      pix_data = PW'($urandom());
      do_start(EXP_W'(e));
      observe_frame(32'hFFFF_FFFF, 32, 0, 1'b0, 16'd0, -1);
      n_checks++; if (obs_expose !== model_expose(e)) $display("FAIL zero_exp%0d_expose got %0d want %0d", e, obs_expose, model_expose(e)); else n_pass++;
      n_checks++; if (obs_strobe_err + obs_order_err + obs_ramp_err !== 0) $display("FAIL zero_exp%0d_phases got %0d bad cycles want 0", e, obs_strobe_err + obs_order_err + obs_ramp_err); else n_pass++;
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      int e = $urandom_range(0, 40);
      logic [31:0] pat = $urandom();
      pix_data = PW'($urandom());
      load_model(pix_data);
      do_start(EXP_W'(e));
      observe_frame(pat, 16, 0, 1'b0, EXP_W'($urandom()), -1);
      n_checks++; if (obs_timeout !== 1'b0) $display("FAIL rand%0d_timeout got %b want 0", f, obs_timeout); else n_pass++;
      n_checks++; if ({obs_erase, obs_expose, obs_convert} !== {ERASE_CYC, model_expose(e), 1 << DATA_W}) $display("FAIL rand%0d_phases got %0d/%0d/%0d want %0d/%0d/%0d", f, obs_erase, obs_expose, obs_convert, ERASE_CYC, model_expose(e), 1 << DATA_W); else n_pass++;
      n_checks++; if (obs_read !== model_read_len(pat, 16)) $display("FAIL rand%0d_read_len got %0d want %0d", f, obs_read, model_read_len(pat, 16)); else n_pass++;
      n_checks++; if (obs_hold_err + obs_ramp_err + obs_strobe_err !== 0) $display("FAIL rand%0d_errors got %0d want 0", f, obs_hold_err + obs_ramp_err + obs_strobe_err); else n_pass++;
      n_checks++; if (obs_words.size() !== N_PIX) $display("FAIL rand%0d_word_count got %0d want %0d", f, obs_words.size(), N_PIX); else n_pass++;
      for (int i = 0; i < N_PIX && i < obs_words.size(); i++) begin
        logic lw = (i == N_PIX - 1);
        n_checks++; if ({obs_lasts[i], obs_words[i]} !== {lw, exp_q[i]}) $display("FAIL rand%0d_word%0d got last=%b data=%h want last=%b data=%h", f, i, obs_lasts[i], obs_words[i], lw, exp_q[i]); else n_pass++;
      end
    end
  endtask

  task automatic test_continuous();
    int busy_cycles = 0;
    continuous = 1'b1;
    pix_data = 32'hA1B2C3D4;
    load_model(pix_data);
    do_start(16'd6);
    // exp_cycles = 2 is what the second frame must latch; start is poked mid-frame.
    observe_frame(32'hFFFF_FFFF, 32, 0, 1'b0, 16'd2, 20);
    n_checks++; if (obs_expose !== 6) $display("FAIL cont1_expose got %0d want 6", obs_expose); else n_pass++;
    n_checks++; if ({obs_end_busy, obs_end_erase} !== 2'b11) $display("FAIL cont1_no_idle got busy=%b erase=%b want 1 1", obs_end_busy, obs_end_erase); else n_pass++;
    n_checks++; if (obs_words.size() !== N_PIX || obs_words[N_PIX-1] !== exp_q[N_PIX-1]) $display("FAIL cont1_words got %0d words want %0d", obs_words.size(), N_PIX); else n_pass++;
    continuous = 1'b0;
    pix_data = 32'h0F1E2D3C;
    load_model(pix_data);
    observe_frame(32'hFFFF_FFFF, 32, 1, 1'b0, 16'd2, -1);
    n_checks++; if (obs_erase !== ERASE_CYC) $display("FAIL cont2_erase got %0d want %0d", obs_erase, ERASE_CYC); else n_pass++;
    n_checks++; if (obs_expose !== 2) $display("FAIL cont2_expose got %0d want 2", obs_expose); else n_pass++;
    for (int i = 0; i < N_PIX && i < obs_words.size(); i++) begin
      n_checks++; if (obs_words[i] !== exp_q[i]) $display("FAIL cont2_word%0d got %h want %h", i, obs_words[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (obs_end_busy !== 1'b0) $display("FAIL cont2_end_idle got busy=%b want 0", obs_end_busy); else n_pass++;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    n_checks++; if (busy_cycles !== 0) $display("FAIL cont_extra_frame got %0d busy cycles want 0", busy_cycles); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic found = 1'b0;
    int dones = 0;
    int busies = 0;
    pix_data = PW'($urandom());
    do_start(16'd4);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (convert && ramp_code == 8'd100) begin found = 1'b1; break; end
    end
    n_checks++; if (found !== 1'b1) $display("FAIL rst_mid_reach_convert got %b want 1", found); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if ({erase, expose, convert, read, busy, frame_done, s_if.out_valid} !== 7'b0) $display("FAIL rst_mid_outputs got %b want 0000000", {erase, expose, convert, read, busy, frame_done, s_if.out_valid}); else n_pass++;
    n_checks++; if (ramp_code !== '0) $display("FAIL rst_mid_ramp got %0d want 0", ramp_code); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rst_mid_state got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (frame_done) dones++;
      if (busy) busies++;
    end
    n_checks++; if ({dones, busies} !== {32'd0, 32'd0}) $display("FAIL rst_mid_quiet got done=%0d busy=%0d want 0 0", dones, busies); else n_pass++;
    pix_data = 32'h44332211;
    load_model(pix_data);
    do_start(16'd10);
    observe_frame(32'hFFFF_FFFF, 32, 0, 1'b0, 16'd10, -1);
    n_checks++; if ({obs_erase, obs_expose, obs_convert} !== {ERASE_CYC, 10, 1 << DATA_W}) $display("FAIL rst_new_phases got %0d/%0d/%0d want %0d/10/%0d", obs_erase, obs_expose, obs_convert, ERASE_CYC, 1 << DATA_W); else n_pass++;
    n_checks++; if (obs_ramp_err !== 0) $display("FAIL rst_new_ramp got %0d bad cycles want 0", obs_ramp_err); else n_pass++;
    for (int i = 0; i < N_PIX && i < obs_words.size(); i++) begin
      n_checks++; if (obs_words[i] !== exp_q[i]) $display("FAIL rst_new_word%0d got %h want %h", i, obs_words[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (obs_fd_gap !== 1) $display("FAIL rst_new_done_gap got %0d want 1", obs_fd_gap); else n_pass++;
  endtask

  task automatic test_late_change();
    pix_data = PW'($urandom());
    load_model(pix_data);
    do_start(16'd2);
    observe_frame(32'b0101, 4, 0, 1'b1, 16'd2, -1);
    n_checks++; if (obs_words.size() !== N_PIX) $display("FAIL late_word_count got %0d want %0d", obs_words.size(), N_PIX); else n_pass++;
    for (int i = 0; i < N_PIX && i < obs_words.size(); i++) begin
      n_checks++; if (obs_words[i] !== exp_q[i]) $display("FAIL late_word%0d got %h want %h", i, obs_words[i], exp_q[i]); else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    s_if.out_ready = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_zero_exposure();
    test_random_frames();
    test_continuous();
    test_reset_mid_frame();
    test_late_change();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
